// File: rtl/load_store_controller.sv
// Load/store sequencer for a single-ported data-memory bus: lane steering,
// byte enables, load extension, misalignment and bus-timeout detection.
module load_store_controller #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_sign_extend,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        error,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam bit               TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cap_off;
  logic [1:0]       cap_size;
  logic             cap_sign;
  logic             cap_write;

  logic             misaligned;
  logic [3:0]       be_next;
  logic [31:0]      wdata_next;
  logic [31:0]      shifted;
  logic [31:0]      load_ext;
  logic             timeout_hit;

  always_comb begin
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = req_wdata;
    case (req_size)
      2'd0: begin
        be_next    = 4'b0001 << req_addr[1:0];
        wdata_next = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        misaligned = req_addr[0];
        be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{req_wdata[15:0]}};
      end
      2'd2: misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Returned word is shifted down to the addressed lane before extension.
  always_comb begin
    shifted = mem_rdata >> {cap_off, 3'b000};
    case (cap_size)
      2'd0:    load_ext = {{24{shifted[7] & cap_sign}}, shifted[7:0]};
      2'd1:    load_ext = {{16{shifted[15] & cap_sign}}, shifted[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LAST);

  // Reset gates stall so the pipeline is released while the controller is held.
  assign stall = req_valid && (state != DONE) && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      cap_off     <= 2'b00;
      cap_size    <= 2'b00;
      cap_sign    <= 1'b0;
      cap_write   <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      load_data   <= 32'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_byte_en <= 4'b0000;
      mem_wdata   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_off   <= req_addr[1:0];
            cap_size  <= req_size;
            cap_sign  <= req_sign_extend;
            cap_write <= req_write;
            if (misaligned) begin
              state     <= DONE;
              done      <= 1'b1;
              error     <= 1'b1;
              load_data <= 32'd0;
            end else begin
              state       <= ACCESS;
              cnt         <= '0;
              mem_req     <= 1'b1;
              mem_we      <= req_write;
              mem_addr    <= {req_addr[31:2], 2'b00};
              mem_byte_en <= be_next;
              mem_wdata   <= wdata_next;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            done      <= 1'b1;
            error     <= 1'b0;
            load_data <= cap_write ? 32'd0 : load_ext;
          end else if (timeout_hit) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            done      <= 1'b1;
            error     <= 1'b1;
            load_data <= 32'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          error     <= 1'b0;
          load_data <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_controller.sv
// Randomized scoreboard bench for load_store_controller with a bus responder
// and an arithmetic reference model of the load/store rules.
module tb_load_store_controller;

  localparam int TIMEOUT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic        req_sign_extend = 1'b0;
  logic [31:0] req_wdata = 32'd0;
  logic        stall;
  logic        done;
  logic        error;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;

  typedef struct {
    logic        err;
    logic [31:0] ld;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;

  load_store_controller #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_size(req_size), .req_sign_extend(req_sign_extend), .req_wdata(req_wdata),
    .stall(stall), .done(done), .error(error), .load_data(load_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: sizes in bytes, extension done by wrapping subtraction.
  task automatic model(input logic w, input logic [31:0] addr, input logic [1:0] size,
                       input logic sign, input logic [31:0] wdata, input logic [31:0] rdata,
                       input int waits, output logic mis, output logic [3:0] be,
                       output logic [31:0] bwdata, output logic err, output logic [31:0] ld);
    int          off;
    logic [31:0] v;
    off = int'(addr % 4);
    mis = (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && off != 0);
    v   = rdata >> (8 * off);
    if (size == 2'd0) begin
      be     = 4'(1 << off);
      bwdata = (wdata & 32'hFF) * 32'h01010101;
      v      = v & 32'hFF;
      if (sign && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      be     = (off >= 2) ? 4'b1100 : 4'b0011;
      bwdata = (wdata & 32'hFFFF) * 32'h00010001;
      v      = v & 32'hFFFF;
      if (sign && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      be     = 4'b1111;
      bwdata = wdata;
      v      = rdata;
    end
    if (mis || waits >= TIMEOUT) begin
      err = 1'b1;
      ld  = 32'd0;
    end else begin
      err = 1'b0;
      ld  = w ? 32'd0 : v;
    end
  endtask

  // Called at a negedge; returns at the negedge where done is visible.
  task automatic apply_stimulus(input logic w, input logic [31:0] addr, input logic [1:0] size,
                                input logic sign, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int waits, input bit b2b);
    logic        mis, err;
    logic [3:0]  be;
    logic [31:0] bwdata, ld;
    int          exp_n, exp_lat, n;
    bit          finished;
    exp_t        e;
    model(w, addr, size, sign, wdata, rdata, waits, mis, be, bwdata, err, ld);
    exp_n   = mis ? 0 : ((waits >= TIMEOUT) ? TIMEOUT : waits + 1);
    exp_lat = (mis ? 1 : exp_n + 1) + (b2b ? 1 : 0);
    e.err = err;
    e.ld  = ld;
    exp_q.push_back(e);
    req_valid = 1'b1; req_write = w; req_addr = addr; req_size = size;
    req_sign_extend = sign; req_wdata = wdata;
    mem_ack = 1'b0; mem_rdata = $urandom;
    n = 0;
    finished = 0;
    for (int i = 0; i < 60 && !finished; i++) begin
      @(negedge clock);
      if (done) begin
        check_output("stall_at_done", 32'(stall), 32'd0);
        check_output("req_cycles", n, exp_n);
        check_output("latency", i + 1, exp_lat);
        finished = 1;
      end else begin
        check_output("stall_busy", 32'(stall), 32'd1);
        if (mem_req) begin
          n++;
          check_output("mem_addr", mem_addr, {addr[31:2], 2'b00});
          check_output("mem_be", 32'(mem_byte_en), 32'(be));
          check_output("mem_we", 32'(mem_we), 32'(w));
          if (w) check_output("mem_wdata", mem_wdata, bwdata);
          if (n - 1 == waits) begin
            mem_ack = 1'b1; mem_rdata = rdata;
          end else begin
            mem_ack = 1'b0; mem_rdata = $urandom;
          end
          req_addr = $urandom; req_wdata = $urandom;
          req_size = 2'($urandom_range(0, 3)); req_write = 1'($urandom_range(0, 1));
        end else begin
          mem_ack = 1'($urandom_range(0, 1));
        end
      end
    end
    if (!finished) begin
      errors++;
      $display("[TB] FAIL done_wait actual=no_done required=done");
    end
    mem_ack = 1'b0;
  endtask

  task automatic idle_cycles(input int k);
    req_valid = 1'b0;
    for (int i = 0; i < k; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clock);
      check_output("idle_mem_req", 32'(mem_req), 32'd0);
      check_output("idle_stall", 32'(stall), 32'd0);
    end
    mem_ack = 1'b0;
  endtask

  // Scoreboard monitor, sampling just after each rising edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        if (done) begin
          check_output("done_pulse", 32'(prev_done), 32'd0);
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_done actual=done required=none");
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_output("error", 32'(error), 32'(e.err));
            check_output("load_data", load_data, e.ld);
          end
        end else begin
          check_output("error_clear", 32'(error), 32'd0);
          check_output("load_clear", load_data, 32'd0);
        end
        prev_done = done;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clock);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_error", 32'(error), 32'd0);
    check_output("rst_load", load_data, 32'd0);
    check_output("rst_req", 32'(mem_req), 32'd0);
    check_output("rst_we", 32'(mem_we), 32'd0);
    check_output("rst_addr", mem_addr, 32'd0);
    check_output("rst_be", 32'(mem_byte_en), 32'd0);
    check_output("rst_wdata", mem_wdata, 32'd0);
    check_output("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;
    idle_cycles(2);

    apply_stimulus(1'b0, 32'h103, 2'd0, 1'b1, 32'd0, 32'h80112233, 0, 0);
    idle_cycles(1);
    apply_stimulus(1'b0, 32'h103, 2'd0, 1'b0, 32'd0, 32'h80112233, 1, 0);
    idle_cycles(1);
    apply_stimulus(1'b1, 32'h202, 2'd1, 1'b0, 32'h0000BEEF, 32'd0, 3, 0);
    idle_cycles(1);
    apply_stimulus(1'b0, 32'h301, 2'd2, 1'b0, 32'd0, 32'd0, 0, 0);
    idle_cycles(1);
    apply_stimulus(1'b0, 32'h600, 2'd2, 1'b0, 32'd0, 32'd0, 1000, 0);
    idle_cycles(1);
    apply_stimulus(1'b0, 32'h400, 2'd2, 1'b0, 32'd0, 32'hCAFEF00D, 0, 0);
    apply_stimulus(1'b0, 32'h406, 2'd1, 1'b1, 32'd0, 32'h80011234, 0, 1);
    idle_cycles(1);

    // Reset in the middle of a bus access.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h500; req_size = 2'd2;
    mem_ack = 1'b0;
    repeat (3) @(negedge clock);
    check_output("pre_rst_req", 32'(mem_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_output("async_req", 32'(mem_req), 32'd0);
    check_output("async_stall", 32'(stall), 32'd0);
    check_output("async_done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    idle_cycles(1);
    apply_stimulus(1'b0, 32'h501, 2'd0, 1'b1, 32'd0, 32'h00007F00, 2, 0);
    idle_cycles(1);

    for (int t = 0; t < 40; t++) begin
      apply_stimulus(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), $urandom, $urandom,
                     int'($urandom_range(0, 5)), 0);
      if ($urandom_range(0, 1) == 1) begin
        apply_stimulus(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 2)),
                       1'($urandom_range(0, 1)), $urandom, $urandom,
                       int'($urandom_range(0, 3)), 1);
      end
      idle_cycles(int'($urandom_range(1, 3)));
    end

    idle_cycles(3);
    check_output("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_controller.md
Name: load_store_controller

Overview:
- Sequences every MEM-stage load/store onto the single-ported data-memory bus, one access at a time.
- Generates word-aligned addresses, byte enables and lane-replicated write data for byte, halfword and word accesses.
- Lane-aligns returned load data, then zero- or sign-extends it to 32 bits.
- Stalls the pipeline until the access completes, and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255: max cycles in ACCESS without mem_ack before abort; 0 disables the timeout.
- CNT_W, 8: timeout counter width; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  MEM stage has a load/store; held until done.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- req_sign_extend  in  1  loads only; 1 = sign-extend, 0 = zero-extend.
- req_wdata  in  32  store data, right-justified.
- stall  out  1  freeze the pipeline.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done: misaligned, illegal size or timeout.
- load_data  out  32  extended load result, valid with done.
- mem_req  out  1  bus request, held until mem_ack.
- mem_we  out  1  bus write enable.
- mem_addr  out  32  {req_addr[31:2], 2'b00}.
- mem_byte_en  out  4  byte lane enables, little-endian.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  bus completion.

Behaviour:
- Reset, asynchronous: state IDLE. All outputs 0, including stall, done, error, load_data, mem_req, mem_we, mem_addr, mem_byte_en and mem_wdata. Timeout counter 0.
- Reset asserted mid-access drops mem_req immediately. Any in-flight bus access is abandoned.
- Outputs are registered except stall.
- stall = req_valid && !(state == DONE), combinational.
- FSM transitions:
  - IDLE, req_valid = 0: remain in IDLE.
  - IDLE, req_valid = 1: capture all req_* fields.
  - IDLE to DONE: if the access is misaligned, set error = 1 and load_data = 0. Misaligned means size 1 with addr[0] = 1, size 2 with addr[1:0] != 0, or size 3. No bus activity occurs.
  - IDLE to ACCESS: for legal requests, set mem_req = 1 and drive mem_we, mem_addr, mem_byte_en and mem_wdata. Clear the counter.
  - ACCESS: bus outputs are held stable.
  - ACCESS, mem_ack = 1: go to DONE. Drop mem_req. For loads, register load_data. error = 0.
  - ACCESS, no ack, TIMEOUT != 0 and counter == TIMEOUT - 1: go to DONE. Drop mem_req. error = 1, load_data = 0.
  - ACCESS, otherwise: counter increments.
  - DONE: done = 1 for exactly one cycle, then unconditionally go to IDLE. done, error and load_data clear on leaving DONE.
- Byte enables: byte 4'b0001 << addr[1:0]; halfword 4'b0011 (addr[1] = 0) or 4'b1100 (addr[1] = 1); word 4'b1111.
- Write data: byte {4{wdata[7:0]}}; halfword {2{wdata[15:0]}}; word wdata.
- Load path: shifted = mem_rdata >> (8*addr[1:0]).
  - byte: low 8 bits, extended from bit 7.
  - halfword: low 16 bits, extended from bit 15.
  - word: passthrough; req_sign_extend is ignored.
- Stores: load_data = 0 at done.
- Minimum latency for a legal access: IDLE, ACCESS (ack same cycle), DONE, so done asserts 2 cycles after req_valid is sampled.
- Misaligned latency: done asserts 1 cycle after sampling.
- Pipeline handshake: stall deasserts during DONE, so the pipeline advances at the end of DONE. req_valid seen in the following IDLE cycle is a new request, giving back-to-back accesses with 1 IDLE cycle between them.
- mem_ack outside ACCESS is ignored.
- req_* changes during ACCESS are ignored; captured values are used.

Test Plan:
- Load byte signed: addr 0x103, size 0, sign 1, rdata 0x80112233 -> mem_addr 0x100, be 4'b1000, load_data 0xFFFFFF80, error 0. Same with sign 0 -> 0x00000080.
- Store halfword: addr 0x202, wdata 0x0000BEEF, ack after 3 wait cycles -> mem_we 1, be 4'b1100, mem_wdata 0xBEEFBEEF. mem_req held 4 cycles, stall high until DONE, one done pulse.
- Misaligned word load at addr 0x301 -> mem_req never asserted; done and error 1 cycle after req_valid; load_data 0.
- Timeout with TIMEOUT = 4 and mem_ack never asserted -> mem_req high exactly 4 cycles, then done = 1 with error = 1; returns to IDLE.
- Back-to-back: word load 0x400 (rdata 0xCAFEF00D), then signed halfword load 0x406 (rdata 0x8001xxxx) -> load_data 0xCAFEF00D, then 0xFFFF8001, one IDLE cycle between.
- Reset asserted during ACCESS -> mem_req, stall and done go to 0 asynchronously; the next request after release completes normally.
